// File: rtl/pipeline_sequencer_if.sv
// Handshake and control bundle between the pipeline sequencer and the datapath/memories.
interface pipeline_sequencer_if;
   logic       imem_req;
   logic       imem_ack;
   logic       dmem_access;
   logic       dmem_req;
   logic       dmem_ack;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [4:0] ex_rd;
   logic       ex_mem_read_enable;
   logic       ex_redirect;
   logic       halt_req;
   logic       pc_en;
   logic       if_id_en;
   logic       id_ex_en;
   logic       ex_mem_en;
   logic       mem_wb_en;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       halted;

   modport master (
      input  imem_ack, dmem_access, dmem_ack, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_rd, ex_mem_read_enable, ex_redirect, halt_req,
      output imem_req, dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, halted
   );

   modport slave (
      output imem_ack, dmem_access, dmem_ack, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_rd, ex_mem_read_enable, ex_redirect, halt_req,
      input  imem_req, dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, halted
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Global-step sequencer for the five-stage core: memory handshakes, load-use bubbles,
// redirect flushes, external halt and a saturating stall-cycle counter.
module pipeline_sequencer #(
   parameter int unsigned CounterSize = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   pipeline_sequencer_if.master   seq_io,
   output logic [CounterSize-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e                 state_q, state_d;
   logic                   fetch_done_q, fetch_done_d;
   logic                   data_done_q, data_done_d;
   logic [CounterSize-1:0] stall_q, stall_d;

   logic run;
   logic step;
   logic load_use;

   assign run  = (state_q == StRun);
   assign step = run & (fetch_done_q | seq_io.imem_ack) &
                 (~seq_io.dmem_access | data_done_q | seq_io.dmem_ack);

   assign load_use = seq_io.ex_mem_read_enable & (seq_io.ex_rd != 5'd0) &
                     ((seq_io.id_uses_rs1 & (seq_io.id_rs1 == seq_io.ex_rd)) |
                      (seq_io.id_uses_rs2 & (seq_io.id_rs2 == seq_io.ex_rd)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         fetch_done_q <= 1'b0;
         data_done_q  <= 1'b0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         fetch_done_q <= fetch_done_d;
         data_done_q  <= data_done_d;
         stall_q      <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StRun;
         StRun:   if (step && seq_io.halt_req) state_d = StHalt;
         StHalt:  if (!seq_io.halt_req) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // Early acks are remembered until the step that consumes them.
   always_comb begin
      fetch_done_d = fetch_done_q | (seq_io.imem_ack & seq_io.imem_req);
      data_done_d  = data_done_q | (seq_io.dmem_ack & seq_io.dmem_req);
      stall_d      = stall_q;
      if (step) begin
         fetch_done_d = 1'b0;
         data_done_d  = 1'b0;
      end
      if (run && !step && (stall_q != {CounterSize{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_comb begin
      seq_io.imem_req    = run & ~fetch_done_q;
      seq_io.dmem_req    = run & seq_io.dmem_access & ~data_done_q;
      seq_io.halted      = (state_q == StHalt);
      seq_io.pc_en       = 1'b0;
      seq_io.if_id_en    = 1'b0;
      seq_io.id_ex_en    = 1'b0;
      seq_io.ex_mem_en   = 1'b0;
      seq_io.mem_wb_en   = 1'b0;
      seq_io.if_id_flush = 1'b0;
      seq_io.id_ex_flush = 1'b0;
      if (step) begin
         seq_io.id_ex_en  = 1'b1;
         seq_io.ex_mem_en = 1'b1;
         seq_io.mem_wb_en = 1'b1;
         if (seq_io.ex_redirect) begin
            seq_io.pc_en       = 1'b1;
            seq_io.if_id_en    = 1'b1;
            seq_io.if_id_flush = 1'b1;
            seq_io.id_ex_flush = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID so the dependent instruction is refetched after the bubble.
            seq_io.id_ex_flush = 1'b1;
         end else begin
            seq_io.pc_en    = 1'b1;
            seq_io.if_id_en = 1'b1;
         end
      end
   end

   assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; inputs change on the falling edge, outputs are
// checked 1 ns later.
module tb_pipeline_sequencer;
   localparam int unsigned CounterSize = 4;

   logic                   clk;
   logic                   rst_n;
   logic [CounterSize-1:0] stall;
   logic                   zw;
   logic                   imem_ack_drv;
   int                     total;
   int                     errors;
   int                     steps;

   pipeline_sequencer_if sif ();

   pipeline_sequencer #(.CounterSize(CounterSize)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .seq_io         (sif.master),
      .stall_cycles_o (stall)
   );

   // Zero-wait instruction memory answers in the same cycle as the request.
   always_comb sif.imem_ack = zw ? sif.imem_req : imem_ack_drv;

   logic [6:0] ctl;
   logic [2:0] rq;
   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
   assign ctl = {sif.pc_en, sif.if_id_en, sif.id_ex_en, sif.ex_mem_en, sif.mem_wb_en,
                 sif.if_id_flush, sif.id_ex_flush};
   // {imem_req, dmem_req, halted}
   assign rq  = {sif.imem_req, sif.dmem_req, sif.halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      zw = 1'b1;
      repeat (2) cyc();
      #1;
      total++;
      if (ctl !== 7'b0 || rq !== 3'b0) begin
         errors++;
         $display("FAIL reset_outputs: ctl=%b rq=%b, required 0000000 000", ctl, rq);
      end
      total++;
      if (stall !== 4'd0) begin
         errors++;
         $display("FAIL reset_stall: got %0d, required 0", stall);
      end
      cyc();
      rst_n = 1'b1;
      #1;
      total++;
      if (rq !== 3'b000) begin
         errors++;
         $display("FAIL idle_cycle: rq=%b, required 000", rq);
      end
      cyc();
      #1;
      total++;
      if (rq !== 3'b100 || ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL first_run: rq=%b ctl=%b, required 100 1111100", rq, ctl);
      end
   endtask

   task automatic test_zero_wait();
      steps = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         #1;
         if (ctl == 7'b1111100) steps++;
      end
      total++;
      if (steps !== 10) begin
         errors++;
         $display("FAIL zero_wait_steps: got %0d, required 10", steps);
      end
      total++;
      if (stall !== 4'd0) begin
         errors++;
         $display("FAIL zero_wait_stall: got %0d, required 0", stall);
      end
   endtask

   task automatic test_wait_states();
      cyc();
      zw = 1'b0; imem_ack_drv = 1'b0; sif.dmem_access = 1'b1; sif.dmem_ack = 1'b0;
      #1;
      total++;
      if (rq !== 3'b110 || ctl !== 7'b0) begin
         errors++;
         $display("FAIL ws_c0: rq=%b ctl=%b, required 110 0000000", rq, ctl);
      end
      cyc();
      sif.dmem_ack = 1'b1;
      #1;
      total++;
      if (ctl !== 7'b0) begin
         errors++;
         $display("FAIL ws_dack_early: ctl=%b, required 0000000", ctl);
      end
      cyc();
      sif.dmem_ack = 1'b0; imem_ack_drv = 1'b1;
      #1;
      total++;
      if (rq !== 3'b100 || ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL ws_step: rq=%b ctl=%b, required 100 1111100", rq, ctl);
      end
      cyc();
      imem_ack_drv = 1'b0;
      #1;
      total++;
      if (stall !== 4'd2 || rq !== 3'b110) begin
         errors++;
         $display("FAIL ws_after: stall=%0d rq=%b, required 2 110", stall, rq);
      end
      // dmem_ack with no data access pending must be ignored.
      sif.dmem_access = 1'b0; sif.dmem_ack = 1'b1;
      cyc();
      sif.dmem_access = 1'b1; sif.dmem_ack = 1'b0; imem_ack_drv = 1'b1;
      #1;
      total++;
      if (rq !== 3'b110 || ctl !== 7'b0) begin
         errors++;
         $display("FAIL ignored_dack: rq=%b ctl=%b, required 110 0000000", rq, ctl);
      end
      cyc();
      imem_ack_drv = 1'b0; sif.dmem_ack = 1'b1;
      #1;
      total++;
      if (rq !== 3'b010 || ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL dack_last: rq=%b ctl=%b, required 010 1111100", rq, ctl);
      end
      cyc();
      sif.dmem_ack = 1'b0; sif.dmem_access = 1'b0; zw = 1'b1;
      #1;
      total++;
      if (stall !== 4'd4) begin
         errors++;
         $display("FAIL ws_stall_total: got %0d, required 4", stall);
      end
   endtask

   task automatic test_load_use();
      cyc();
      sif.ex_mem_read_enable = 1'b1; sif.ex_rd = 5'd5;
      sif.id_rs1 = 5'd5; sif.id_rs2 = 5'd1; sif.id_uses_rs1 = 1'b1; sif.id_uses_rs2 = 1'b1;
      #1;
      total++;
      if (ctl !== 7'b0011101) begin
         errors++;
         $display("FAIL load_use_bubble: ctl=%b, required 0011101", ctl);
      end
      cyc();
      sif.ex_mem_read_enable = 1'b0; sif.ex_rd = 5'd0;
      #1;
      total++;
      if (ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL after_bubble: ctl=%b, required 1111100", ctl);
      end
      cyc();
      sif.ex_mem_read_enable = 1'b1; sif.ex_rd = 5'd0; sif.id_rs1 = 5'd0;
      #1;
      total++;
      if (ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL rd_zero: ctl=%b, required 1111100", ctl);
      end
      cyc();
      sif.ex_rd = 5'd9; sif.id_rs1 = 5'd3; sif.id_rs2 = 5'd9; sif.id_uses_rs2 = 1'b0;
      #1;
      total++;
      if (ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL rs2_unused: ctl=%b, required 1111100", ctl);
      end
      cyc();
      sif.id_uses_rs2 = 1'b1;
      #1;
      total++;
      if (ctl !== 7'b0011101) begin
         errors++;
         $display("FAIL rs2_match: ctl=%b, required 0011101", ctl);
      end
   endtask

   task automatic test_redirect();
      cyc();
      sif.ex_redirect = 1'b1;
      #1;
      total++;
      if (ctl !== 7'b1111111) begin
         errors++;
         $display("FAIL redirect_wins: ctl=%b, required 1111111", ctl);
      end
      cyc();
      sif.ex_redirect = 1'b0; sif.ex_mem_read_enable = 1'b0;
   endtask

   task automatic test_halt();
      cyc();
      zw = 1'b0; imem_ack_drv = 1'b0; sif.halt_req = 1'b1;
      #1;
      total++;
      if (rq !== 3'b100 || ctl !== 7'b0) begin
         errors++;
         $display("FAIL halt_wait: rq=%b ctl=%b, required 100 0000000", rq, ctl);
      end
      cyc();
      imem_ack_drv = 1'b1;
      #1;
      total++;
      if (ctl !== 7'b1111100) begin
         errors++;
         $display("FAIL halt_step: ctl=%b, required 1111100", ctl);
      end
      cyc();
      sif.dmem_access = 1'b1;
      #1;
      total++;
      if (rq !== 3'b001 || ctl !== 7'b0 || stall !== 4'd5) begin
         errors++;
         $display("FAIL halted: rq=%b ctl=%b stall=%0d, required 001 0000000 5", rq, ctl, stall);
      end
      cyc();
      sif.halt_req = 1'b0; sif.dmem_access = 1'b0; imem_ack_drv = 1'b0;
      #1;
      total++;
      if (rq !== 3'b001) begin
         errors++;
         $display("FAIL halt_release_cycle: rq=%b, required 001", rq);
      end
      cyc();
      #1;
      total++;
      if (rq !== 3'b100 || stall !== 4'd5) begin
         errors++;
         $display("FAIL resume: rq=%b stall=%0d, required 100 5", rq, stall);
      end
   endtask

   task automatic test_async_reset();
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      imem_ack_drv = 1'b1; sif.dmem_access = 1'b1;
      cyc();
      imem_ack_drv = 1'b0;
      repeat (6) cyc();
      #1;
      total++;
      if (stall !== 4'd7 || rq !== 3'b010) begin
         errors++;
         $display("FAIL pre_reset: stall=%0d rq=%b, required 7 010", stall, rq);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (stall !== 4'd0 || rq !== 3'b000 || ctl !== 7'b0) begin
         errors++;
         $display("FAIL async_reset: stall=%0d rq=%b ctl=%b, required 0 000 0000000",
                  stall, rq, ctl);
      end
      sif.dmem_access = 1'b0;
   endtask

   task automatic test_saturate();
      cyc();
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         #1;
         if (k == 16) begin
            total++;
            if (stall !== 4'd15) begin
               errors++;
               $display("FAIL stall_reach_max: got %0d, required 15", stall);
            end
         end
      end
      total++;
      if (stall !== 4'd15) begin
         errors++;
         $display("FAIL stall_saturate: got %0d, required 15", stall);
      end
   endtask

   initial begin
      total = 0; errors = 0; steps = 0;
      rst_n = 1'b0; zw = 1'b0; imem_ack_drv = 1'b0;
      sif.dmem_access = 1'b0; sif.dmem_ack = 1'b0;
      sif.id_rs1 = 5'd0; sif.id_rs2 = 5'd0; sif.id_uses_rs1 = 1'b0; sif.id_uses_rs2 = 1'b0;
      sif.ex_rd = 5'd0; sif.ex_mem_read_enable = 1'b0; sif.ex_redirect = 1'b0;
      sif.halt_req = 1'b0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_load_use();
      test_redirect();
      test_halt();
      test_async_reset();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1);
   end
endmodule
